pattern_apply_capture: RTL and testbench

- Sequential stimulus/response harness for the contest-mapped combinational benchmarks (14 PIs, 8 POs).
- Generates PI vectors with an LFSR and drives them onto the netlist's primary inputs.
- Waits a settle window, then samples the primary outputs, folds them into a MISR signature and streams each response out over a valid/ready port.
- Sits on the opposite side of the netlist: it drives what the netlist consumes and consumes what the netlist produces.

---
 rtl/pattern_apply_capture.sv | 120 ++++++++++++
 tb/tb_pattern_apply_capture.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_apply_capture.sv
// LFSR-driven stimulus / MISR-compacting response harness for a 14-PI, 8-PO
// combinational netlist; each captured response is streamed over valid/ready.
module pattern_apply_capture #(
  parameter int PI_W   = 14,
  parameter int PO_W   = 8,
  parameter int SETTLE = 2,
  parameter int IDX_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [IDX_W-1:0]      num_vec,
  input  logic [PI_W-1:0]       seed,
  output logic [PI_W-1:0]       pi_out,
  input  logic [PO_W-1:0]       po_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W+PO_W-1:0] out_data,
  output logic [PO_W-1:0]       signature,
  output logic                  busy,
  output logic                  done
);

  // state     | meaning
  // S_IDLE    | waiting for start
  // S_APPLY   | vector on pi_out, settle counter running
  // S_CAPTURE | sample po_in into MISR and response register
  // S_WAIT_OUT| response beat presented, waiting for out_ready
  // S_DONE    | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_CAPTURE, S_WAIT_OUT, S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t           state, state_nxt;
  logic [PI_W-1:0]  lfsr;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] nv_q;
  logic [PO_W-1:0]  sig;
  logic             last;
  logic [PI_W-1:0]  lfsr_step;
  logic [PO_W-1:0]  misr_nxt;

  assign last      = (index == nv_q - IDX_W'(1));
  assign lfsr_step = {lfsr[12:0], ~(lfsr[13] ^ lfsr[4] ^ lfsr[2] ^ lfsr[0])};
  assign misr_nxt  = {sig[6:0], sig[7] ^ sig[5] ^ sig[4] ^ sig[3]} ^ po_in;

  assign pi_out    = lfsr;
  assign signature = sig;
  assign busy      = (state == S_APPLY) || (state == S_CAPTURE) || (state == S_WAIT_OUT);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start) state_nxt = (num_vec != '0) ? S_APPLY : S_DONE;
      S_APPLY:    if (cnt == 4'd1) state_nxt = S_CAPTURE;
      S_CAPTURE:  state_nxt = S_WAIT_OUT;
      S_WAIT_OUT: if (out_ready) state_nxt = last ? S_DONE : S_APPLY;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= '0;
      cnt       <= '0;
      index     <= '0;
      nv_q      <= '0;
      sig       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (abort && state != S_IDLE) begin
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sig <= '0;
            if (num_vec != '0) begin
              // all-ones is the XNOR-LFSR lock-up state
              lfsr  <= (seed == {PI_W{1'b1}}) ? '0 : seed;
              index <= '0;
              cnt   <= SETTLE_C;
              nv_q  <= num_vec;
            end
          end
        end
        S_APPLY: cnt <= cnt - 4'd1;
        S_CAPTURE: begin
          sig       <= misr_nxt;
          out_data  <= {index, po_in};
          out_valid <= 1'b1;
        end
        S_WAIT_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!last) begin
              index <= index + IDX_W'(1);
              lfsr  <= lfsr_step;
              cnt   <= SETTLE_C;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_apply_capture.sv
// Directed bench for pattern_apply_capture: expected beats go into a queue,
// a negedge monitor pops and compares on every handshake.
module tb_pattern_apply_capture;

  localparam int PI_W = 14, PO_W = 8, SETTLE = 2, IDX_W = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic                  abort = 1'b0;
  logic [IDX_W-1:0]      num_vec = '0;
  logic [PI_W-1:0]       seed = '0;
  logic [PI_W-1:0]       pi_out;
  logic [PO_W-1:0]       po_in;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [IDX_W+PO_W-1:0] out_data;
  logic [PO_W-1:0]       signature;
  logic                  busy;
  logic                  done;

  logic                  po_mode = 1'b0;   // 0: po follows pi_out[7:0], 1: constant
  logic [PO_W-1:0]       po_const = '0;
  assign po_in = po_mode ? po_const : pi_out[7:0];

  always #5 clk = ~clk;

  pattern_apply_capture #(.PI_W(PI_W), .PO_W(PO_W), .SETTLE(SETTLE), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_vec(num_vec),
    .seed(seed), .pi_out(pi_out), .po_in(po_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .signature(signature),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [IDX_W+PO_W-1:0] data;
    logic [PI_W-1:0]       pi;
    logic [PO_W-1:0]       sig;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    done_cnt = 0;
  int    settle_cnt = 0;
  logic  prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] idx, input logic [7:0] po,
                      input logic [13:0] pi, input logic [7:0] sg);
    beat_t b;
    b.data = {idx, po};
    b.pi   = pi;
    b.sig  = sg;
    exp_q.push_back(b);
  endtask

  // monitor: handshake checks, settle-length checks, done pulse counting
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!busy) settle_cnt = 0;
    else if (!out_valid) settle_cnt++;
    if (out_valid && !prev_valid) begin
      check("settle_cycles", settle_cnt, SETTLE + 1);
      settle_cnt = 0;
    end
    prev_valid = out_valid;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", out_data, 32'hDEAD_BEEF);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("out_data", out_data, b.data);
        check("pi_out", pi_out, b.pi);
        check("signature", signature, b.sig);
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(input logic [15:0] nv, input logic [13:0] sd);
    num_vec = nv;
    seed    = sd;
    start   = 1'b1;
    step();
    start   = 1'b0;
    num_vec = 16'hFFFF;   // later changes must not be resampled
    seed    = 14'h1234;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || done) && n < 200) begin
      step();
      n++;
    end
    check({name, "_timeout"}, (n < 200), 1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 200) begin
      step();
      n++;
    end
    check({name, "_timeout"}, (n < 200), 1);
  endtask

  int d0;

  initial begin
    #12;
    check("rst_pi_out", pi_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_signature", signature, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    step(2);

    // basic run: seed 1 -> 0001, 0002, 0005; po = pi[7:0]
    out_ready = 1'b1;
    push(0, 8'h01, 14'h0001, 8'h01);
    push(1, 8'h02, 14'h0002, 8'h00);
    push(2, 8'h05, 14'h0005, 8'h05);
    d0 = done_cnt;
    start_run(3, 14'h0001);
    check("busy_after_start", busy, 1);
    wait_idle("basic");
    step(2);
    check("basic_done_once", done_cnt - d0, 1);
    check("basic_q_empty", exp_q.size(), 0);
    check("basic_sig_hold", signature, 8'h05);

    // po tied FF: signature FF then 01
    po_mode = 1'b1; po_const = 8'hFF;
    push(0, 8'hFF, 14'h0001, 8'hFF);
    push(1, 8'hFF, 14'h0002, 8'h01);
    start_run(2, 14'h0001);
    wait_idle("po_ff");
    check("po_ff_sig", signature, 8'h01);

    // po tied 00: signature stays 00
    po_const = 8'h00;
    push(0, 8'h00, 14'h0001, 8'h00);
    push(1, 8'h00, 14'h0002, 8'h00);
    start_run(2, 14'h0001);
    wait_idle("po_00");
    check("po_00_sig", signature, 8'h00);
    po_mode = 1'b0;

    // backpressure: hold out_ready low 5 cycles on first beat
    out_ready = 1'b0;
    push(0, 8'h01, 14'h0001, 8'h01);
    push(1, 8'h02, 14'h0002, 8'h00);
    start_run(2, 14'h0001);
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 24'h0000_01);
      check("bp_pi", pi_out, 14'h0001);
    end
    out_ready = 1'b1;
    wait_idle("bp");
    check("bp_q_empty", exp_q.size(), 0);

    // num_vec = 0: done next cycle, no beat, signature cleared
    d0 = done_cnt;
    start_run(0, 14'h0001);
    check("nv0_done", done, 1);
    check("nv0_busy", busy, 0);
    check("nv0_sig", signature, 8'h00);
    step();
    check("nv0_done_low", done, 0);
    check("nv0_valid", out_valid, 0);
    step(2);
    check("nv0_done_once", done_cnt - d0, 1);

    // lock-up seed
    push(0, 8'h00, 14'h0000, 8'h00);
    push(1, 8'h01, 14'h0001, 8'h01);
    start_run(2, 14'h3FFF);
    wait_idle("lockup");
    check("lockup_q_empty", exp_q.size(), 0);

    // abort during APPLY of vector 1
    d0 = done_cnt;
    push(0, 8'h01, 14'h0001, 8'h01);
    start_run(3, 14'h0001);
    wait_valid("abort");
    step();                      // handshake edge -> APPLY of vector 1
    check("abort_in_apply", busy && !out_valid, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_sig_hold", signature, 8'h01);
    step(6);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_q_empty", exp_q.size(), 0);

    // reset pulse during WAIT_OUT
    out_ready = 1'b0;
    d0 = done_cnt;
    start_run(3, 14'h0001);
    wait_valid("rst");
    rst_n = 1'b0;
    #2;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_pi", pi_out, 0);
    check("rst_mid_sig", signature, 0);
    check("rst_mid_busy", busy, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(5);
    check("rst_no_beat", out_valid, 0);
    check("rst_no_done", done_cnt - d0, 0);

    // fresh run after reset
    push(0, 8'h00, 14'h0000, 8'h00);
    push(1, 8'h01, 14'h0001, 8'h01);
    push(2, 8'h02, 14'h0002, 8'h00);
    d0 = done_cnt;
    start_run(3, 14'h3FFF);
    wait_idle("fresh");
    step(2);
    check("fresh_done_once", done_cnt - d0, 1);
    check("fresh_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
